// File: rtl/end_state_ctrl.sv
// End-of-battle sequencer: freezes play when an HP hits zero, shows the win/lose banner,
// and issues a single restart pulse after Enter is pressed and released. Define END_BLINK_EN to blink the banner.
module end_state_ctrl #(
    parameter int unsigned DELAY_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [7:0]  ENTER_KEY    = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [3:0] status_in,
    input  logic [7:0] player_hp,
    input  logic [7:0] boss_hp,
    input  logic [7:0] keycode,
    output logic [3:0] status,
    output logic       freeze,
    output logic       banner_on,
    output logic       restart
);

    typedef enum logic [2:0] {
        S_PLAY,
        S_DELAY,
        S_WIN,
        S_LOSE,
        S_RELEASE,
        S_REARM
    } state_t;

    localparam logic [7:0] L_DELAY_LAST = 8'(DELAY_FRAMES - 1);
    localparam logic [7:0] L_BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_lose;
    logic       w_lose_next;
    logic [3:0] r_status;
    logic [3:0] w_status_next;
    logic       r_freeze;
    logic       w_freeze_next;
    logic       r_banner;
    logic       w_banner_next;
    logic       r_restart;
    logic       w_restart_next;

    logic       r_fc_s1;
    logic       r_fc_s2;
    logic       r_fc_d;
    logic       r_tick;

    logic       w_battle;
    logic [3:0] w_end_status;
    logic       w_in_end;
    logic       w_banner_adv;

    // frame_clk crosses into Clk here; r_tick is a one-cycle pulse per vsync rising edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fc_s1 <= 1'b0;
            r_fc_s2 <= 1'b0;
            r_fc_d  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_fc_s1 <= frame_clk;
            r_fc_s2 <= r_fc_s1;
            r_fc_d  <= r_fc_s2;
            r_tick  <= r_fc_s2 & ~r_fc_d;
        end
    end

    assign w_battle     = (status_in != 4'd0) && (status_in <= 4'd5);
    assign w_end_status = r_lose ? 4'd7 : 4'd6;
    assign w_in_end     = (r_state == S_WIN) || (r_state == S_LOSE) || (r_state == S_RELEASE);

`ifdef END_BLINK_EN
    logic [7:0] r_blink_cnt;
    logic [7:0] w_blink_cnt_adv;

    always_comb begin
        w_blink_cnt_adv = r_blink_cnt;
        w_banner_adv    = r_banner;
        if (r_tick) begin
            if (r_blink_cnt == L_BLINK_LAST) begin
                w_blink_cnt_adv = 8'd0;
                w_banner_adv    = ~r_banner;
            end else begin
                w_blink_cnt_adv = r_blink_cnt + 8'd1;
            end
        end
    end

    // Held at zero outside the end screen so every banner starts a fresh half-period
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_blink_cnt <= 8'd0;
        end else begin
            r_blink_cnt <= w_in_end ? w_blink_cnt_adv : 8'd0;
        end
    end
`else
    logic w_unused_blink;
    assign w_unused_blink = ^L_BLINK_LAST;
    assign w_banner_adv   = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_PLAY;
            r_cnt     <= 8'd0;
            r_lose    <= 1'b0;
            r_status  <= 4'd0;
            r_freeze  <= 1'b0;
            r_banner  <= 1'b0;
            r_restart <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_lose    <= w_lose_next;
            r_status  <= w_status_next;
            r_freeze  <= w_freeze_next;
            r_banner  <= w_banner_next;
            r_restart <= w_restart_next;
        end
    end

    // Outputs are computed for the next state so they register together with it
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_lose_next    = r_lose;
        w_status_next  = r_status;
        w_freeze_next  = r_freeze;
        w_banner_next  = r_banner;
        w_restart_next = 1'b0;

        case (r_state)
            S_PLAY: begin
                w_status_next = status_in;
                w_freeze_next = 1'b0;
                w_banner_next = 1'b0;
                if (w_battle && ((player_hp == 8'd0) || (boss_hp == 8'd0))) begin
                    w_lose_next   = (player_hp == 8'd0);
                    w_state_next  = S_DELAY;
                    w_cnt_next    = 8'd0;
                    w_freeze_next = 1'b1;
                end
            end
            S_DELAY: begin
                w_freeze_next = 1'b1;
                w_banner_next = 1'b0;
                if (r_tick) begin
                    if (r_cnt == L_DELAY_LAST) begin
                        w_state_next  = r_lose ? S_LOSE : S_WIN;
                        w_cnt_next    = 8'd0;
                        w_status_next = w_end_status;
                        w_banner_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                w_status_next = w_end_status;
                w_freeze_next = 1'b1;
                w_banner_next = w_banner_adv;
                if (keycode == ENTER_KEY) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_status_next = w_end_status;
                w_freeze_next = 1'b1;
                w_banner_next = w_banner_adv;
                if (keycode != ENTER_KEY) begin
                    w_state_next   = S_REARM;
                    w_restart_next = 1'b1;
                    w_status_next  = status_in;
                    w_freeze_next  = 1'b0;
                    w_banner_next  = 1'b0;
                end
            end
            S_REARM: begin
                // Wait for the title screen so a stale zero HP cannot retrigger the end screen
                w_status_next = status_in;
                w_freeze_next = 1'b0;
                w_banner_next = 1'b0;
                if (status_in == 4'd0) begin
                    w_state_next = S_PLAY;
                end
            end
            default: begin
                w_state_next = S_PLAY;
            end
        endcase
    end

    assign status    = r_status;
    assign freeze    = r_freeze;
    assign banner_on = r_banner;
    assign restart   = r_restart;

endmodule
